// File: rtl/wisc_mem_pkg.sv
// Shared types and widths for the unified-memory arbiter and the memory model.
// The arbiter FSM states live here so benches and debug tooling can decode them.
package wisc_mem_pkg;

    localparam int WISC_ADDR_W = 16;
    localparam int WISC_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } mem_arb_state_t;

endpackage

// File: rtl/mem_arb_ctrl_if.sv
// Handshake bus between the arbiter (master) and the single-port unified memory (slave).
interface mem_arb_ctrl_if
    import wisc_mem_pkg::*;
#(
    parameter int ADDR_W = WISC_ADDR_W,
    parameter int DATA_W = WISC_DATA_W
) ();

    logic              m_en;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_stall;
    logic              m_done;

    modport master (
        output m_en, m_wr, m_addr, m_wdata,
        input  m_rdata, m_stall, m_done
    );

    modport slave (
        input  m_en, m_wr, m_addr, m_wdata,
        output m_rdata, m_stall, m_done
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Clearable saturating wait counter; hit flags the increment that reaches TIMEOUT,
// so the owner can leave its wait state on that same edge.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign hit = inc && (count == LAST);

endmodule

// File: rtl/mem_arb_ctrl.sv
// Arbiter/sequencer sharing the single-port unified memory between fetch and data stages.
// Data requests win over fetches; one access is in flight at a time.
module mem_arb_ctrl
    import wisc_mem_pkg::*;
#(
    parameter int ADDR_W  = WISC_ADDR_W,
    parameter int DATA_W  = WISC_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    mem_arb_ctrl_if.master    mem,
    output logic              pipe_stall,
    output logic              err
);

    mem_arb_state_t    state;
    mem_arb_state_t    state_nxt;

    logic [1:0]        rst_pipe;
    logic              rst_int_n;

    logic              d_any;
    logic              issue_en;
    logic              ctr_inc;
    logic              ctr_hit;

    logic              lat_data;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    // Assertion is immediate, release is aligned to clk after two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_int_n = rst_pipe[1];

    assign d_any = d_rd | d_wr;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (d_any || if_req) state_nxt = ST_ISSUE;
            ST_ISSUE: if (!mem.m_stall)    state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (mem.m_done) begin
                    state_nxt = ST_RESP;
                end else if (ctr_hit) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_RESP:  state_nxt = ST_IDLE;
            ST_ERR:   state_nxt = ST_ERR;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_en = 1'b0;
        ctr_inc  = 1'b0;
        if_valid = 1'b0;
        d_valid  = 1'b0;
        err      = 1'b0;
        case (state)
            ST_ISSUE: issue_en = ~mem.m_stall;
            ST_WAIT:  ctr_inc  = ~mem.m_done;
            ST_RESP: begin
                if_valid = ~lat_data;
                d_valid  = lat_data;
            end
            ST_ERR:   err = 1'b1;
            default:  ;
        endcase
    end

    // Request latch: a write with d_rd also high is still a write.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lat_data  <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == ST_IDLE) begin
            if (d_any) begin
                lat_data  <= 1'b1;
                lat_wr    <= d_wr;
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
            end else if (if_req) begin
                lat_data  <= 1'b0;
                lat_wr    <= 1'b0;
                lat_addr  <= if_addr;
            end
        end
    end

    // Read data is captured only for the requester that owns the access; writes leave both untouched.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if ((state == ST_WAIT) && mem.m_done) begin
            if (!lat_data) begin
                if_rdata <= mem.m_rdata;
            end else if (!lat_wr) begin
                d_rdata <= mem.m_rdata;
            end
        end
    end

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst_n (rst_int_n),
        .clr   (issue_en),
        .inc   (ctr_inc),
        .hit   (ctr_hit)
    );

    assign mem.m_en    = issue_en;
    assign mem.m_wr    = lat_wr;
    assign mem.m_addr  = lat_addr;
    assign mem.m_wdata = lat_wdata;

    assign pipe_stall = err | (d_any & ~d_valid) | (if_req & ~if_valid);

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Self-checking bench: transaction-level schedule model of the arbiter driving a randomized
// memory, with a per-cycle compare process and a few literal timing/data pins.
module tb_mem_arb_ctrl;
    import wisc_mem_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_rd = 1'b0;
    logic          d_wr = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          pipe_stall;
    logic          err;

    mem_arb_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mbus ();

    mem_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .d_rd       (d_rd),
        .d_wr       (d_wr),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_valid    (d_valid),
        .mem        (mbus),
        .pipe_stall (pipe_stall),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            m_en;
        bit            m_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            wchk;
        bit            if_valid;
        bit            d_valid;
        bit            err;
        logic [DW-1:0] if_rdata;
        logic [DW-1:0] d_rdata;
    } exp_t;

    exp_t exp_c;
    bit   exp_live = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int            act_en_cyc = -1;
    int            act_valid_cyc = -1;
    int            err_cyc = -1;
    int            en_count = 0;
    int            low_cnt = 0;
    logic [AW-1:0] act_en_addr;
    logic [DW-1:0] act_en_wdata;
    logic          act_en_wr;

    // Behavioural memory and architectural output state.
    bit [DW-1:0] mem_m [bit [AW-1:0]];
    logic [DW-1:0] m_if_rdata = '0;
    logic [DW-1:0] m_d_rdata  = '0;
    bit            m_err      = 1'b0;

    initial begin
        mbus.m_rdata = '0;
        mbus.m_stall = 1'b0;
        mbus.m_done  = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 16'hA5A5;
    endfunction

    // Compare process: every cycle, DUT outputs vs the model's expectation for that cycle.
    always @(negedge clk) begin
        if (exp_live) begin
            check("m_en", 32'(mbus.m_en), 32'(exp_c.m_en));
            if (exp_c.m_en) begin
                check("m_wr", 32'(mbus.m_wr), 32'(exp_c.m_wr));
                check("m_addr", 32'(mbus.m_addr), 32'(exp_c.addr));
                if (exp_c.wchk) check("m_wdata", 32'(mbus.m_wdata), 32'(exp_c.wdata));
            end
            check("if_valid", 32'(if_valid), 32'(exp_c.if_valid));
            check("d_valid", 32'(d_valid), 32'(exp_c.d_valid));
            check("err", 32'(err), 32'(exp_c.err));
            check("if_rdata", 32'(if_rdata), 32'(exp_c.if_rdata));
            check("d_rdata", 32'(d_rdata), 32'(exp_c.d_rdata));
            check("pipe_stall", 32'(pipe_stall),
                  32'(exp_c.err | ((d_rd | d_wr) & ~exp_c.d_valid) | (if_req & ~exp_c.if_valid)));
        end
        if (mbus.m_en === 1'b1) begin
            act_en_cyc   = cyc;
            en_count++;
            act_en_addr  = mbus.m_addr;
            act_en_wdata = mbus.m_wdata;
            act_en_wr    = mbus.m_wr;
        end
        if ((if_valid === 1'b1) || (d_valid === 1'b1)) act_valid_cyc = cyc;
        if ((err === 1'b1) && (err_cyc < 0)) err_cyc = cyc;
        if (pipe_stall !== 1'b1) low_cnt++;
    end

    task automatic step(input bit en, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input bit wchk, input bit ifv, input bit dv);
        exp_c.m_en     = en;
        exp_c.m_wr     = wr;
        exp_c.addr     = addr;
        exp_c.wdata    = wdata;
        exp_c.wchk     = wchk;
        exp_c.if_valid = ifv;
        exp_c.d_valid  = dv;
        exp_c.err      = m_err;
        exp_c.if_rdata = m_if_rdata;
        exp_c.d_rdata  = m_d_rdata;
        exp_live       = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic noise();
        mbus.m_stall = 1'($urandom_range(0, 1));
        mbus.m_done  = ($urandom_range(0, 3) == 0);
        mbus.m_rdata = 16'($urandom);
    endtask

    task automatic drop();
        if_req = 1'b0;
        d_rd   = 1'b0;
        d_wr   = 1'b0;
    endtask

    task automatic idle(input int n);
        drop();
        for (int i = 0; i < n; i++) begin
            noise();
            step_idle();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drop();
        mbus.m_done = 1'b0;
        #1;
        check("rst_m_en", 32'(mbus.m_en), 32'd0);
        check("rst_m_wr", 32'(mbus.m_wr), 32'd0);
        check("rst_m_addr", 32'(mbus.m_addr), 32'd0);
        check("rst_m_wdata", 32'(mbus.m_wdata), 32'd0);
        check("rst_valids", 32'({if_valid, d_valid}), 32'd0);
        check("rst_err_stall", 32'({err, pipe_stall}), 32'd0);
        check("rst_if_rdata", 32'(if_rdata), 32'd0);
        check("rst_d_rdata", 32'(d_rdata), 32'd0);
        m_if_rdata = '0;
        m_d_rdata  = '0;
        m_err      = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
    endtask

    // One access from the cycle its request is first seen in IDLE through its RESP cycle.
    // s = stalled ISSUE cycles, d = cycles from m_en to m_done (d > TO never completes),
    // rst_at = WAIT cycle at which reset is applied (0 = none).
    task automatic do_access(input bit is_data, input bit wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int s, input int d,
                             input int rst_at, output bit aborted);
        logic [DW-1:0] rd;
        bit            ewr;
        aborted = 1'b0;
        ewr     = is_data && wr;
        if (is_data) begin
            d_addr  = addr;
            d_wdata = wdata;
            d_wr    = wr;
            d_rd    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
            d_rd    = 1'b0;
            d_wr    = 1'b0;
            if_req  = 1'b1;
            if_addr = addr;
        end
        noise();
        step_idle();
        for (int k = 1; k <= s; k++) begin
            noise();
            mbus.m_stall = 1'b1;
            step_idle();
        end
        noise();
        mbus.m_stall = 1'b0;
        step(1'b1, ewr, addr, wdata, ewr, 1'b0, 1'b0);
        rd = mem_read(addr);
        for (int j = 1; j <= d; j++) begin
            if (j == rst_at) begin
                do_reset();
                aborted = 1'b1;
                return;
            end
            noise();
            if (j == d) begin
                mbus.m_done  = 1'b1;
                mbus.m_rdata = rd;
                step_idle();
            end else begin
                mbus.m_done = 1'b0;
                step_idle();
                if (j == TO) begin
                    m_err   = 1'b1;
                    aborted = 1'b1;
                    return;
                end
            end
        end
        if (ewr) mem_m[addr] = wdata;
        else if (is_data) m_d_rdata = rd;
        else m_if_rdata = rd;
        noise();
        step(1'b0, 1'b0, '0, '0, 1'b0, !is_data, is_data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit            ab;
        int            start;
        int            l0;
        int            e0;
        logic [AW-1:0] ra;

        @(posedge clk);
        #1;
        do_reset();

        // Fetch only, best case.
        mem_m[16'h0010] = 16'h4A21;
        start = cyc;
        do_access(1'b0, 1'b0, 16'h0010, '0, 0, 1, 0, ab);
        check("tp1_en_cycle", 32'(act_en_cyc - start), 32'd1);
        check("tp1_valid_cycle", 32'(act_valid_cyc - start), 32'd3);
        drop();
        #1;
        check("tp1_if_rdata", 32'(if_rdata), 32'h4A21);
        check("tp1_stall_c4", 32'(pipe_stall), 32'd0);
        idle(1);

        // Contention: data read first, fetch after an IDLE cycle.
        mem_m[16'h0200] = 16'hBEEF;
        mem_m[16'h0012] = 16'h7C03;
        start = cyc;
        l0 = low_cnt;
        if_req  = 1'b1;
        if_addr = 16'h0012;
        do_access(1'b1, 1'b0, 16'h0200, '0, 0, 1, 0, ab);
        check("tp2_d_valid_cycle", 32'(act_valid_cyc - start), 32'd3);
        check("tp2_d_rdata", 32'(d_rdata), 32'hBEEF);
        do_access(1'b0, 1'b0, 16'h0012, '0, 0, 1, 0, ab);
        check("tp2_if_valid_cycle", 32'(act_valid_cyc - start), 32'd7);
        check("tp2_if_rdata", 32'(if_rdata), 32'h7C03);
        check("tp2_stall_low_cycles", 32'(low_cnt - l0), 32'd1);
        idle(2);

        // Write held off by three stall cycles.
        start = cyc;
        do_access(1'b1, 1'b1, 16'h0300, 16'h1234, 3, 1, 0, ab);
        check("tp3_en_cycle", 32'(act_en_cyc - start), 32'd4);
        check("tp3_en_fields", {act_en_wr, 15'd0, act_en_addr}, 32'h8000_0300);
        check("tp3_en_wdata", 32'(act_en_wdata), 32'h1234);
        check("tp3_d_rdata_kept", 32'(d_rdata), 32'hBEEF);
        check("tp3_valid_cycle", 32'(act_valid_cyc - start), 32'd6);
        idle(1);

        // Randomized traffic, including back-to-back and the longest completing wait.
        for (int t = 0; t < 160; t++) begin
            int kind;
            int s;
            int d;
            kind = $urandom_range(0, 3);
            s    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            d    = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(1, 4);
            ra   = 16'h0100 + 16'(2 * $urandom_range(0, 7));
            drop();
            case (kind)
                0: do_access(1'b0, 1'b0, ra, '0, s, d, 0, ab);
                1: do_access(1'b1, 1'b0, ra, '0, s, d, 0, ab);
                2: do_access(1'b1, 1'b1, ra, 16'($urandom), s, d, 0, ab);
                default: begin
                    if_req  = 1'b1;
                    if_addr = 16'h0180 + 16'(2 * $urandom_range(0, 3));
                    do_access(1'b1, 1'($urandom_range(0, 1)), ra, 16'($urandom), s, d, 0, ab);
                    do_access(1'b0, 1'b0, if_addr, '0, $urandom_range(0, 2),
                              $urandom_range(1, 3), 0, ab);
                end
            endcase
            idle($urandom_range(0, 2));
        end

        // Timeout: m_done never returns.
        err_cyc = -1;
        start = cyc;
        do_access(1'b1, 1'b0, 16'h0040, '0, 1, TO + 1, 0, ab);
        e0 = en_count;
        for (int i = 0; i < 6; i++) begin
            if_req = 1'($urandom_range(0, 1));
            d_rd   = 1'($urandom_range(0, 1));
            noise();
            mbus.m_done = 1'b1;
            step_idle();
        end
        check("to_err_cycle", 32'(err_cyc - start), 32'd18);
        check("to_no_strobe", 32'(en_count - e0), 32'd0);
        check("to_err_sticky", 32'({err, pipe_stall}), 32'd3);
        do_reset();

        // Reset in the middle of WAIT, then a fresh best-case fetch.
        do_access(1'b1, 1'b0, 16'h0050, '0, 0, 5, 3, ab);
        start = cyc;
        do_access(1'b0, 1'b0, 16'h0010, '0, 0, 1, 0, ab);
        check("rst_fetch_en_cycle", 32'(act_en_cyc - start), 32'd1);
        check("rst_fetch_valid_cycle", 32'(act_valid_cyc - start), 32'd3);
        check("rst_fetch_if_rdata", 32'(if_rdata), 32'h4A21);
        idle(2);

        exp_live = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arb_ctrl.md
# mem_arb_ctrl

Sequencer and arbiter that shares the single-port, variable-latency unified memory between the instruction-fetch stage and the data-memory stage. It accepts level requests from both stages, grants data accesses over fetches, drives the memory handshake, returns read data with a one-cycle valid pulse, and raises `pipe_stall` while any request is outstanding. It sits between the fetch/memory stages and the memory model. The decoded `mem_write` and `mem_to_reg` controls feed its data-request inputs.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `TIMEOUT`, 15, maximum cycles in WAIT before error (≥1)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset: asynchronous, active-low
- `if_req`  in  1  fetch request, level, held until `if_valid`
- `if_addr`  in  ADDR_W  fetch address (PC)
- `if_rdata`  out  DATA_W  fetched instruction, valid with `if_valid`
- `if_valid`  out  1  one-cycle fetch completion pulse
- `d_rd`  in  1  data read request, level
- `d_wr`  in  1  data write request, level
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_rdata`  out  DATA_W  read data, valid with `d_valid`
- `d_valid`  out  1  one-cycle data completion pulse (reads and writes)
- `m_en`  out  1  memory access strobe, one cycle per access
- `m_wr`  out  1  write qualifier for `m_en`
- `m_addr`  out  ADDR_W  memory address
- `m_wdata`  out  DATA_W  memory write data
- `m_rdata`  in  DATA_W  memory read data, valid with `m_done`
- `m_stall`  in  1  memory busy; `m_en` is not accepted while high
- `m_done`  in  1  one-cycle access-complete pulse
- `pipe_stall`  out  1  stall to pipeline
- `err`  out  1  sticky memory-timeout error

## Operation
- States: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - If `d_rd|d_wr`, latch the data request (address, wdata, write = `d_wr`) and go to ISSUE.
  - Otherwise, if `if_req`, latch the fetch request and go to ISSUE.
  - Data has fixed priority over fetch.
- `d_rd` and `d_wr` both high is treated as a write.
- ISSUE:
  - `m_en = ~m_stall`.
  - `m_addr`, `m_wr` and `m_wdata` come from the latched request.
  - When `m_en` is high, clear the timeout counter and go to WAIT. Otherwise hold in ISSUE indefinitely; there is no timeout here.
- WAIT:
  - On `m_done`, capture `m_rdata` into `if_rdata` (fetch) or `d_rdata` (data read) and go to RESP.
  - A data write captures nothing.
  - Otherwise increment the counter; if it reaches TIMEOUT, go to ERR.
- RESP:
  - Pulse `if_valid` or `d_valid` for the latched requester.
  - Go to IDLE.
  - Request inputs are ignored in this cycle; the requester drops or changes its request on the next edge.
- ERR:
  - `err=1` and `pipe_stall=1`.
  - No memory strobes are issued.
  - Left only by reset.
- `pipe_stall = err | (d_rd|d_wr) & ~d_valid | if_req & ~if_valid`, combinational.
- `m_done` outside WAIT is ignored.
- Counter width is `$clog2(TIMEOUT+1)` and it does not wrap.

## Timing
- Reset (async assert, sync deassert internally):
  - state=IDLE.
  - `if_valid`, `d_valid`, `m_en`, `m_wr`, `err` = 0.
  - `m_addr`, `m_wdata`, `if_rdata`, `d_rdata` = 0.
- Reset mid-access abandons the access. No valid pulse is produced.
- Best-case latency with the request seen at cycle 0, `m_stall=0`, and `m_done` in the cycle after `m_en`:
  - `m_en` at cycle 1.
  - `m_done` at cycle 2.
  - valid at cycle 3.
- Back-to-back accesses have a one-cycle IDLE gap, giving a minimum of 4 cycles per access.
- Simultaneous data and fetch request: the data access completes first. `pipe_stall` stays high through the data `d_valid` cycle. The fetch is issued after IDLE.
- `m_en` is high for exactly one cycle per access, never in IDLE, WAIT, RESP or ERR.

## Structure
- Package `wisc_mem_pkg`:
  - state enum `mem_arb_state_t`
  - `WISC_ADDR_W` and `WISC_DATA_W` constants, shared with the memory model
- One sub-module, `mem_timeout_ctr`: a clearable saturating counter with a `hit` output at TIMEOUT.
- FSM, request latch and output registers stay in `mem_arb_ctrl`.

## Test plan
- Fetch only: `if_req=1`, `if_addr=0x0010`, memory returns `0x4A21` one cycle after `m_en` → `m_en` at cycle 1, `if_valid=1` with `if_rdata=0x4A21` at cycle 3, `pipe_stall` 0 at cycle 4 after the request drops.
- Contention: `if_req`, `d_rd` at `0x0200` (`0xBEEF`) and fetch `0x0012` asserted together → `d_valid` with `0xBEEF` first, then `if_valid`; `pipe_stall` high continuously until `if_valid`.
- Write plus stall: `d_wr`, `addr 0x0300`, `wdata 0x1234`, `m_stall` high for 3 cycles → `m_en` held off, then `m_en=1, m_wr=1, m_addr=0x0300, m_wdata=0x1234` for one cycle; `d_valid` pulses; `d_rdata` unchanged.
- Timeout: `d_rd` issued, `m_done` never returns, TIMEOUT=15 → state ERR after 15 WAIT cycles; `err=1`, `pipe_stall=1`, no further `m_en`; a late `m_done` is ignored.
- Reset mid-WAIT: assert `rst_n=0` during WAIT → all outputs 0 immediately; after release, a fresh `if_req` completes normally with best-case timing.
